ppu_vram_port: RTL

- Sits directly downstream of the PPU register-select/decode stage.
- Consumes its decoded write/read strobes for $2000, $2005, $2006 and $2007, the first/second write split and I_1_32.
- Maintains the scroll/address registers T and V and fine X (FH). Runs the CPU-side $2007 VRAM access sequencer with the read buffer.
- Applies the rendering-driven V increments and copies.

---
 rtl/ppu_vram_pkg.sv | 10 +
 rtl/ppu_v_incr.sv | 28 ++
 rtl/ppu_vram_port.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ppu_vram_pkg.sv
// ppu_vram_pkg: shared state encoding and loopy-register field layout
package ppu_vram_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, INC} state_e;
   localparam int CX_LSB        = 0;
   localparam int CY_LSB        = 5;
   localparam int NT_LSB        = 10;
   localparam int FY_LSB        = 12;
   localparam int INC_ROW       = 32;
   localparam int COARSE_Y_LAST = 29;
endpackage

// File: rtl/ppu_v_incr.sv
// ppu_v_incr: next-V functions for rendering increments and $2007 stepping
module ppu_v_incr
   import ppu_vram_pkg::*;
(
   input  logic [14:0] v_i,
   input  logic        h_inc_i,
   input  logic        v_inc_i,
   input  logic        i_1_32_i,
   output logic [14:0] v_ren_o,
   output logic [14:0] v_step_o
);
   // coarse-X and Y increments touch disjoint fields, so both may apply at once
   always_comb begin
      v_ren_o = v_i;
      if (h_inc_i) begin
         v_ren_o[CX_LSB +: 5] = v_i[CX_LSB +: 5] + 5'd1;
         if (&v_i[CX_LSB +: 5]) v_ren_o[NT_LSB] = ~v_i[NT_LSB];
      end
      if (v_inc_i) begin
         v_ren_o[FY_LSB +: 3] = v_i[FY_LSB +: 3] + 3'd1;
         if (&v_i[FY_LSB +: 3]) begin
            v_ren_o[CY_LSB +: 5] = (v_i[CY_LSB +: 5] == 5'(COARSE_Y_LAST) || &v_i[CY_LSB +: 5]) ? 5'd0 : v_i[CY_LSB +: 5] + 5'd1;
            if (v_i[CY_LSB +: 5] == 5'(COARSE_Y_LAST)) v_ren_o[NT_LSB + 1] = ~v_i[NT_LSB + 1];
         end
      end
   end
   assign v_step_o = v_i + (i_1_32_i ? 15'(INC_ROW) : 15'd1);
endmodule

// File: rtl/ppu_vram_port.sv
// ppu_vram_port: scroll/address registers and CPU-side $2007 VRAM sequencer
module ppu_vram_port
   import ppu_vram_pkg::*;
#(
   parameter int VA_W    = 14,
   parameter int ACK_TMO = 15
) (
   input  logic            CLK,
   input  logic            n_RES,
   input  logic [7:0]      DB_in,
   input  logic            n_W0,
   input  logic            n_W5_1,
   input  logic            n_W5_2,
   input  logic            n_W6_1,
   input  logic            n_W6_2,
   input  logic            n_W7,
   input  logic            n_R7,
   input  logic            I_1_32,
   input  logic            RENDER,
   input  logic            H_INC,
   input  logic            V_INC,
   input  logic            COPY_H,
   input  logic            COPY_V,
   input  logic            VACK,
   input  logic [7:0]      VRDATA,
   output logic            VREQ,
   output logic            VWE,
   output logic [VA_W-1:0] VADDR,
   output logic [7:0]      VWDATA,
   output logic [2:0]      FH,
   output logic [7:0]      DB_out,
   output logic            DB_oe,
   output logic            TMO
);
   localparam int CW = $clog2(ACK_TMO + 1);
   logic [14:0]     t_q, v_q, v_d, v_ren, v_step;
   logic [2:0]      fh_q;
   logic [7:0]      rbuf_q, wdata_q;
   logic [VA_W-1:0] addr_q;
   logic [CW-1:0]   cnt_q;
   logic            vreq_q, vwe_q, tmo_q;
   state_e          state_q;

   ppu_v_incr u_incr (
      .v_i      (v_q),
      .h_inc_i  (H_INC),
      .v_inc_i  (V_INC),
      .i_1_32_i (I_1_32),
      .v_ren_o  (v_ren),
      .v_step_o (v_step)
   );

   // next V: $2006 load beats the $2007 step, which beats copies, which beat increments
   always_comb begin
      v_d = v_q;
      if (!n_W6_2) v_d = {t_q[14:8], DB_in};
      else if (state_q == INC) v_d = v_step;
      else if (COPY_H || COPY_V) begin
         if (COPY_H) {v_d[10], v_d[4:0]} = {t_q[10], t_q[4:0]};
         if (COPY_V) {v_d[14:11], v_d[9:5]} = {t_q[14:11], t_q[9:5]};
      end
      else v_d = v_ren;
   end

   // CPU register writes into T and fine X, plus the V update
   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         t_q  <= '0;
         v_q  <= '0;
         fh_q <= '0;
      end else begin
         v_q <= v_d;
         if (!n_W0) t_q[11:10] <= DB_in[1:0];
         if (!n_W5_1) {t_q[4:0], fh_q} <= DB_in;
         if (!n_W5_2) {t_q[9:5], t_q[14:12]} <= DB_in;
         if (!n_W6_1) t_q[14:8] <= {1'b0, DB_in[5:0]};
         if (!n_W6_2) t_q[7:0] <= DB_in;
      end
   end

   // $2007 access sequencer; address is frozen for the whole access
   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         state_q <= IDLE;
         vreq_q  <= 1'b0;
         vwe_q   <= 1'b0;
         tmo_q   <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
      end else begin
         tmo_q <= 1'b0;
         case (state_q)
            IDLE: if (!RENDER && (!n_W7 || !n_R7)) begin
               vreq_q  <= 1'b1;
               vwe_q   <= !n_W7;
               cnt_q   <= '0;
               addr_q  <= v_q[VA_W-1:0];
               state_q <= ACCESS;
               if (!n_W7) wdata_q <= DB_in;
            end
            ACCESS: if (VACK) begin
               vreq_q  <= 1'b0;
               state_q <= INC;
               if (!vwe_q) rbuf_q <= VRDATA;
            end else if (cnt_q == CW'(ACK_TMO - 1)) begin
               vreq_q  <= 1'b0;
               tmo_q   <= 1'b1;
               state_q <= IDLE;
            end else cnt_q <= cnt_q + 1'b1;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign VREQ   = vreq_q;
   assign VWE    = vwe_q;
   assign VADDR  = (state_q == IDLE) ? v_q[VA_W-1:0] : addr_q;
   assign VWDATA = wdata_q;
   assign FH     = fh_q;
   assign DB_out = rbuf_q;
   assign DB_oe  = !n_R7;
   assign TMO    = tmo_q;
endmodule
